// File: rtl/mem_y_pingpong_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_y_pingpong_ctrl
// Brief    : Two-bank ping-pong frame buffer sequencer for a 1024x24 simple
//            dual-port block RAM (port A write, port B read, 1-cycle read
//            latency). The producer fills one bank while the consumer drains
//            the other through a valid/ready stream with a 2-entry skid.
// Revision : 1.0 - initial release
// ============================================================================
module mem_y_pingpong_ctrl #(
    parameter int DATA_W    = 24,
    parameter int ADDR_W    = 10,
    parameter int FRAME_LEN = 512
) (
    input  logic              clk,
    input  logic              reset,
    // producer stream
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    // consumer stream
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    input  logic              m_ready,
    // RAM control
    output logic              mem_cea,
    output logic [ADDR_W-1:0] mem_ada,
    output logic [DATA_W-1:0] mem_din,
    output logic              mem_ceb,
    output logic [ADDR_W-1:0] mem_adb,
    output logic              mem_oce,
    output logic              mem_reseta,
    output logic              mem_resetb,
    input  logic [DATA_W-1:0] mem_dout,
    // frame events
    output logic              frame_wr_done,
    output logic              frame_rd_done
);

    // Address within a bank; the bank bit is prepended as the RAM address MSB.
    localparam int              C_BA_W      = ADDR_W - 1;
    localparam logic [C_BA_W-1:0] C_LAST_ADDR = C_BA_W'(FRAME_LEN - 1);
    localparam logic [C_BA_W-1:0] C_ADDR_ONE  = C_BA_W'(1);

    // Bank / address / fullness state
    logic              wbank_q, wbank_d;
    logic              rbank_q, rbank_d;
    logic [C_BA_W-1:0] waddr_q, waddr_d;
    logic [C_BA_W-1:0] raddr_q, raddr_d;
    logic [1:0]        full_q, full_d;
    // Read pipeline: a read issued last cycle lands on mem_dout this cycle
    logic              inflight_q, inflight_d;
    logic              inflight_last_q, inflight_last_d;
    logic              frame_wr_done_q, frame_wr_done_d;
    // Output skid: entry 0 is always the head
    logic [DATA_W-1:0] skid0_data_q, skid0_data_d;
    logic [DATA_W-1:0] skid1_data_q, skid1_data_d;
    logic              skid0_last_q, skid0_last_d;
    logic              skid1_last_q, skid1_last_d;
    logic [1:0]        occ_q, occ_d;

    logic              w_wr_accept;
    logic              w_wr_last;
    logic              w_pop;
    logic [2:0]        w_fill;
    logic              w_issue;
    logic              w_rd_last;

    // Handshake decode, read-issue decision and all RAM/stream outputs
    always_comb begin
        s_ready     = !reset && !full_q[wbank_q];
        w_wr_accept = s_valid && s_ready;
        w_wr_last   = (waddr_q == C_LAST_ADDR);

        m_valid     = !reset && (occ_q != 2'd0);
        m_data      = skid0_data_q;
        m_last      = m_valid && skid0_last_q;
        w_pop       = m_valid && m_ready;

        // Entries the skid will have to hold if nothing more is issued;
        // a new read is allowed only while that leaves room for one more.
        w_fill      = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, w_pop};
        w_issue     = !reset && full_q[rbank_q] && (w_fill < 3'd2);
        w_rd_last   = (raddr_q == C_LAST_ADDR);

        mem_cea       = w_wr_accept;
        mem_ada       = {wbank_q, waddr_q};
        mem_din       = s_data;
        mem_ceb       = w_issue;
        mem_adb       = {rbank_q, raddr_q};
        mem_oce       = 1'b1;
        mem_reseta    = reset;
        mem_resetb    = reset;
        frame_wr_done = !reset && frame_wr_done_q;
        frame_rd_done = w_pop && skid0_last_q;
    end

    // Next-state for the write side, the read side and the bank full flags
    always_comb begin
        wbank_d         = wbank_q;
        rbank_d         = rbank_q;
        waddr_d         = waddr_q;
        raddr_d         = raddr_q;
        full_d          = full_q;
        inflight_d      = w_issue;
        inflight_last_d = w_issue && w_rd_last;
        frame_wr_done_d = w_wr_accept && w_wr_last;

        if (w_wr_accept) begin
            if (w_wr_last) begin
                waddr_d = '0;
                wbank_d = !wbank_q;
            end else begin
                waddr_d = waddr_q + C_ADDR_ONE;
            end
        end

        if (w_issue) begin
            if (w_rd_last) begin
                raddr_d = '0;
                rbank_d = !rbank_q;
            end else begin
                raddr_d = raddr_q + C_ADDR_ONE;
            end
        end

        // Clear and set always address different banks, so order is moot.
        if (w_issue && w_rd_last) begin
            full_d[rbank_q] = 1'b0;
        end
        if (w_wr_accept && w_wr_last) begin
            full_d[wbank_q] = 1'b1;
        end
    end

    // Skid next-state: capture returning RAM data, shift on consumer pop
    always_comb begin
        skid0_data_d = skid0_data_q;
        skid1_data_d = skid1_data_q;
        skid0_last_d = skid0_last_q;
        skid1_last_d = skid1_last_q;
        occ_d        = occ_q;

        unique case ({inflight_q, w_pop})
            2'b10: begin
                if (occ_q == 2'd0) begin
                    skid0_data_d = mem_dout;
                    skid0_last_d = inflight_last_q;
                end else begin
                    skid1_data_d = mem_dout;
                    skid1_last_d = inflight_last_q;
                end
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                skid0_data_d = skid1_data_q;
                skid0_last_d = skid1_last_q;
                occ_d        = occ_q - 2'd1;
            end
            2'b11: begin
                if (occ_q == 2'd1) begin
                    skid0_data_d = mem_dout;
                    skid0_last_d = inflight_last_q;
                end else begin
                    skid0_data_d = skid1_data_q;
                    skid0_last_d = skid1_last_q;
                    skid1_data_d = mem_dout;
                    skid1_last_d = inflight_last_q;
                end
            end
            default: begin
            end
        endcase
    end

    // State registers; reset drops both banks, the skid and any in-flight read
    always_ff @(posedge clk) begin
        if (reset) begin
            wbank_q         <= 1'b0;
            rbank_q         <= 1'b0;
            waddr_q         <= '0;
            raddr_q         <= '0;
            full_q          <= 2'b00;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            frame_wr_done_q <= 1'b0;
            skid0_data_q    <= '0;
            skid1_data_q    <= '0;
            skid0_last_q    <= 1'b0;
            skid1_last_q    <= 1'b0;
            occ_q           <= 2'd0;
        end else begin
            wbank_q         <= wbank_d;
            rbank_q         <= rbank_d;
            waddr_q         <= waddr_d;
            raddr_q         <= raddr_d;
            full_q          <= full_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            frame_wr_done_q <= frame_wr_done_d;
            skid0_data_q    <= skid0_data_d;
            skid1_data_q    <= skid1_data_d;
            skid0_last_q    <= skid0_last_d;
            skid1_last_q    <= skid1_last_d;
            occ_q           <= occ_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_y_pingpong_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_y_pingpong_ctrl
// Brief    : Scoreboard bench for mem_y_pingpong_ctrl with FRAME_LEN=16 and a
//            behavioural 1024x24 RAM with 1-cycle registered read.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_y_pingpong_ctrl;

    localparam int DW = 24;
    localparam int AW = 10;
    localparam int FL = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          s_valid = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic          s_ready;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          m_ready = 1'b0;
    logic          mem_cea, mem_ceb, mem_oce, mem_reseta, mem_resetb;
    logic [AW-1:0] mem_ada, mem_adb;
    logic [DW-1:0] mem_din;
    logic [DW-1:0] mem_dout = '0;
    logic          frame_wr_done, frame_rd_done;

    mem_y_pingpong_ctrl #(.DATA_W(DW), .ADDR_W(AW), .FRAME_LEN(FL)) dut (
        .clk(clk), .reset(reset),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready),
        .mem_cea(mem_cea), .mem_ada(mem_ada), .mem_din(mem_din),
        .mem_ceb(mem_ceb), .mem_adb(mem_adb), .mem_oce(mem_oce),
        .mem_reseta(mem_reseta), .mem_resetb(mem_resetb), .mem_dout(mem_dout),
        .frame_wr_done(frame_wr_done), .frame_rd_done(frame_rd_done)
    );

    always #5 clk = ~clk;

    // Behavioural block RAM
    logic [DW-1:0] ram [0:1023];
    always @(posedge clk) begin
        if (mem_cea) ram[mem_ada] <= mem_din;
        if (mem_ceb) mem_dout <= ram[mem_adb];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard and reference state
    logic [DW:0]   sb [$];
    logic [DW:0]   e;
    logic [AW-1:0] wexp = '0;
    logic [AW-1:0] rexp = '0;
    int  n_sent = 0, stall_cycles = 0, last_acc_cyc = 0, first_valid_cyc = -1;
    int  wr_done_cnt = 0, rd_done_cnt = 0, out_cnt = 0, wr_cnt = 0;
    int  both_cnt = 0, diff_cnt = 0;
    int  mode = 0;
    bit  stall_watch = 0;
    bit  hold_prev = 0;
    logic [DW-1:0] prev_data = '0;
    logic          prev_last = 1'b0;

    function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a);
        if (a[AW-2:0] == (AW-1)'(FL - 1)) return {~a[AW-1], {(AW-1){1'b0}}};
        return a + AW'(1);
    endfunction

    // Consumer ready: 0 = stalled, 1 = always ready, 2 = random
    initial forever begin
        @(negedge clk);
        m_ready = (mode == 2) ? 1'($urandom_range(0, 1)) : (mode == 1);
    end

    // Monitor: checks RAM addressing, output ordering and hold stability
    initial forever begin
        @(negedge clk);
        #2;
        if (reset) begin
            hold_prev = 0;
        end else begin
            if (mem_cea) begin
                check("wr_addr", 32'(mem_ada), 32'(wexp));
                check("wr_data", 32'(mem_din), 32'(s_data));
                wexp = next_addr(wexp);
                wr_cnt++;
            end
            if (stall_watch) check("stall_cea", 32'(mem_cea), 0);
            if (mem_ceb) begin
                check("rd_addr", 32'(mem_adb), 32'(rexp));
                rexp = next_addr(rexp);
            end
            if (mem_cea && mem_ceb) begin
                both_cnt++;
                if (mem_ada[AW-1] != mem_adb[AW-1]) diff_cnt++;
            end
            if (hold_prev) begin
                check("hold_valid", 32'(m_valid), 1);
                check("hold_data", 32'(m_data), 32'(prev_data));
                check("hold_last", 32'(m_last), 32'(prev_last));
            end
            if (m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (m_valid && m_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_beat", 32'(m_valid), 0);
                end else begin
                    e = sb.pop_front();
                    check("out_data", 32'(m_data), 32'(e[DW-1:0]));
                    check("out_last", 32'(m_last), 32'(e[DW]));
                    check("rd_done_beat", 32'(frame_rd_done), 32'(e[DW]));
                end
                out_cnt++;
            end
            if (frame_wr_done) wr_done_cnt++;
            if (frame_rd_done) rd_done_cnt++;
            hold_prev = m_valid && !m_ready;
            prev_data = m_data;
            prev_last = m_last;
        end
    end

    // Present one sample (called at a negedge); returns at the negedge after accept
    task automatic send(input logic [DW-1:0] v);
        int waited = 0;
        s_valid = 1'b1;
        s_data  = v;
        while (!s_ready && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        stall_cycles += waited;
        if (!s_ready) begin
            check("send_timeout", 32'(s_ready), 1);
            s_valid = 1'b0;
            return;
        end
        sb.push_back({(n_sent % FL == FL - 1), v});
        last_acc_cyc = cyc + 1;
        n_sent++;
        @(negedge clk);
    endtask

    task automatic drain(input string nm);
        int w = 0;
        while ((sb.size() != 0 || m_valid) && w < 1000) begin
            @(negedge clk);
            w++;
        end
        check({nm, "_drain"}, 32'(sb.size()), 0);
    endtask

    task automatic clear_counts();
        wr_done_cnt = 0; rd_done_cnt = 0; out_cnt = 0; wr_cnt = 0;
        stall_cycles = 0; both_cnt = 0; diff_cnt = 0; first_valid_cyc = -1;
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_s_ready", 32'(s_ready), 0);
        check("rst_m_valid", 32'(m_valid), 0);
        check("rst_cea", 32'(mem_cea), 0);
        check("rst_ceb", 32'(mem_ceb), 0);
        check("rst_reseta", 32'(mem_reseta), 1);
        check("rst_resetb", 32'(mem_resetb), 1);
        check("rst_oce", 32'(mem_oce), 1);
        check("rst_done", 32'({frame_wr_done, frame_rd_done}), 0);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_s_ready", 32'(s_ready), 1);
        check("post_rst_reseta", 32'(mem_reseta), 0);

        // One frame, consumer always ready
        mode = 1;
        clear_counts();
        for (int i = 1; i <= FL; i++) send(DW'(i));
        s_valid = 1'b0;
        drain("t1");
        check("t1_no_stall", 32'(stall_cycles), 0);
        check("t1_latency", 32'(first_valid_cyc), 32'(last_acc_cyc + 2));
        check("t1_wr_done", 32'(wr_done_cnt), 1);
        check("t1_rd_done", 32'(rd_done_cnt), 1);
        check("t1_outs", 32'(out_cnt), 16);

        // Consumer stalled: two frames buffered, third back-pressured
        mode = 0;
        clear_counts();
        for (int i = 1; i <= 2 * FL; i++) send(DW'(32'h1000 + i));
        s_valid = 1'b1;
        s_data  = DW'(32'h1000 + 2 * FL + 1);
        stall_watch = 1;
        for (int k = 0; k < 10; k++) begin
            check("t2_s_ready_low", 32'(s_ready), 0);
            @(negedge clk);
        end
        stall_watch = 0;
        mode = 1;
        for (int i = 2 * FL + 1; i <= 3 * FL; i++) send(DW'(32'h1000 + i));
        s_valid = 1'b0;
        drain("t2");
        check("t2_wr_done", 32'(wr_done_cnt), 3);
        check("t2_rd_done", 32'(rd_done_cnt), 3);
        check("t2_outs", 32'(out_cnt), 48);

        // Random consumer readiness
        mode = 2;
        clear_counts();
        for (int i = 1; i <= 3 * FL; i++) send(DW'(32'h2000 + i));
        s_valid = 1'b0;
        mode = 1;
        drain("t3");
        check("t3_rd_done", 32'(rd_done_cnt), 3);
        check("t3_outs", 32'(out_cnt), 48);

        // Continuous producer, ready consumer: one write and one read per cycle
        clear_counts();
        for (int i = 1; i <= 4 * FL; i++) send(DW'(32'h3000 + i));
        s_valid = 1'b0;
        drain("t4");
        check("t4_no_stall", 32'(stall_cycles), 0);
        check("t4_overlap", 32'(both_cnt), 48);
        check("t4_bank_split", 32'(diff_cnt), 48);
        check("t4_rd_done", 32'(rd_done_cnt), 4);

        // Reset in the middle of readout
        clear_counts();
        for (int i = 1; i <= FL; i++) send(DW'(32'h4000 + i));
        s_valid = 1'b0;
        for (int w = 0; w < 200 && out_cnt < 6; w++) @(negedge clk);
        check("t5_six_out", 32'(out_cnt), 6);
        reset = 1'b1;
        #3;
        check("t5_rst_m_valid", 32'(m_valid), 0);
        @(negedge clk);
        check("t5_m_valid", 32'(m_valid), 0);
        check("t5_s_ready", 32'(s_ready), 0);
        check("t5_ceb", 32'(mem_ceb), 0);
        sb.delete();
        wexp = '0;
        rexp = '0;
        n_sent = 0;
        reset = 1'b0;
        @(negedge clk);
        check("t5_s_ready_rel", 32'(s_ready), 1);
        check("t5_m_valid_rel", 32'(m_valid), 0);
        clear_counts();
        for (int i = 1; i <= FL; i++) send(DW'(32'h5000 + i));
        s_valid = 1'b0;
        drain("t5");
        check("t5_rd_done", 32'(rd_done_cnt), 1);
        check("t5_outs", 32'(out_cnt), 16);

        // Producer with gaps
        clear_counts();
        for (int i = 1; i <= FL; i++) begin
            send(DW'(32'h6000 + i));
            s_valid = 1'b0;
            @(negedge clk);
        end
        drain("t6");
        check("t6_writes", 32'(wr_cnt), 16);
        check("t6_wr_done", 32'(wr_done_cnt), 1);
        check("t6_rd_done", 32'(rd_done_cnt), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/mem_y_pingpong_ctrl.md
Name: mem_y_pingpong_ctrl

Overview:
- Sequences one 1024x24 simple dual-port block RAM (port A write, port B read, bypass read mode, 1-cycle read latency) as a two-bank ping-pong frame buffer.
- A producer streams 24-bit beamformer Y samples into one 512-word bank while a consumer drains the other bank through a valid/ready stream.
- Sits between the Y-accumulation datapath and the image/readout stage; owns every RAM control pin.

Parameters:
- DATA_W, 24, sample width; equals RAM data width.
- ADDR_W, 10, RAM address width; MSB is the bank select.
- FRAME_LEN, 512, samples per frame; legal range 2..2^(ADDR_W-1).

Ports:
- clk  in  1  single clock for the block and both RAM ports.
- reset  in  1  synchronous, active-high reset.
- s_valid  in  1  producer sample valid.
- s_data  in  DATA_W  producer sample.
- s_ready  out  1  controller can accept a sample.
- m_valid  out  1  output sample valid.
- m_data  out  DATA_W  output sample.
- m_last  out  1  marks the final sample of a frame.
- m_ready  in  1  consumer accepts the sample.
- mem_cea  out  1  RAM port A write enable.
- mem_ada  out  ADDR_W  RAM write address.
- mem_din  out  DATA_W  RAM write data.
- mem_ceb  out  1  RAM port B read enable.
- mem_adb  out  ADDR_W  RAM read address.
- mem_oce  out  1  RAM output clock enable; constant 1.
- mem_reseta  out  1  RAM port A reset.
- mem_resetb  out  1  RAM port B reset.
- mem_dout  in  DATA_W  RAM read data; valid in the cycle after a mem_ceb edge.
- frame_wr_done  out  1  1-cycle pulse after a bank fills.
- frame_rd_done  out  1  1-cycle pulse when the m_last beat is accepted.

Behaviour:
- State: wbank, rbank (1 bit each); waddr, raddr (ADDR_W-1 bits each); full[1:0]; inflight (1 bit); 2-entry output skid FIFO.
- Reset (reset sampled high at an edge): all state cleared.
  - s_ready=0 while reset is high.
  - m_valid=0, m_last=0, mem_cea=0, mem_ceb=0, both done pulses 0.
  - mem_reseta=mem_resetb=reset.
  - Skid contents are discarded and in-flight reads are dropped. Reset mid-frame loses both banks.
- Write side:
  - s_ready = !reset & !full[wbank].
  - Accept = s_valid & s_ready. On accept: mem_cea=1, mem_ada={wbank,waddr}, mem_din=s_data (combinational), and waddr increments.
  - If waddr==FRAME_LEN-1: waddr<=0, full[wbank]<=1, wbank toggles, frame_wr_done pulses next cycle.
- Read issue:
  - Condition: full[rbank] & (occ + inflight - pop) < 2, where pop = m_valid & m_ready.
  - On issue: mem_ceb=1, mem_adb={rbank,raddr}, inflight<=1, raddr increments.
  - On the final address: raddr<=0, full[rbank]<=0, rbank toggles. The bank is immediately writable; the read was already sampled.
  - If no issue that cycle, inflight<=0.
- Capture: when inflight=1, mem_dout is pushed into the skid together with a last flag (the registered last-address marker).
- Output: m_valid = skid non-empty; m_data and m_last come from the skid head and are held stable while m_valid & !m_ready.
- Latency: last producer beat accepted at edge E0 → read issued at E1 → capture at E2 → m_valid=1 after E2.
- Throughput: 1 sample per clock when m_ready is held high. Two frames buffered maximum; a third frame backpressures via s_ready=0.
- Simultaneous events:
  - A set of full[wbank] and a clear of full[rbank] in the same cycle always target different banks; both take effect.
  - Push and pop in the same cycle leave occupancy unchanged.
- Address wrap: waddr and raddr wrap at FRAME_LEN, not at 2^(ADDR_W-1).

Test Plan:
- FRAME_LEN=16, reset then write samples 0x000001..0x000010 with m_ready=1 → s_ready=1 throughout; m_valid rises 2 clocks after the 16th accept; outputs 0x000001..0x000010 back-to-back; m_last only on 0x000010; one frame_wr_done and one frame_rd_done pulse.
- m_ready=0, write 3 frames of 16 → frames 1 and 2 accepted; s_ready=0 from the first cycle of frame 3; mem_cea never asserts during the stall; after m_ready=1, all 48 samples emerge in order.
- Random m_ready (50%) during a continuous producer → no sample lost or duplicated; m_data stable while m_valid & !m_ready; the skid never exceeds 2 entries.
- Producer continuous, m_ready=1 → steady state of 1 write and 1 read per cycle; writes alternate banks (mem_ada MSB toggles every 16 writes); the MSB of mem_adb lags by one frame.
- Reset asserted mid-readout (sample 7 of 16) → next cycle m_valid=0 and s_ready=0; after release, s_ready=1, full=0, and the next frame writes to address 0x000.
- Producer gaps (s_valid toggling 1/0) → waddr advances only on accept; the frame completes on the 16th accept; the mem_adb sequence is {bank,0..15}.
